// File: rtl/noc_pkg.sv
// Shared NoC types: output-port enumeration, port count and the route controller state type.
package noc_pkg;

  localparam int NUM_PORTS = 5;

  typedef enum logic [2:0] {
    NORTH = 3'd0,
    EAST  = 3'd1,
    SOUTH = 3'd2,
    WEST  = 3'd3,
    LOCAL = 3'd4
  } port_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } state_e;

  function automatic logic [NUM_PORTS-1:0] port_onehot(input port_e p);
    logic [NUM_PORTS-1:0] oh;
    oh    = '0;
    oh[p] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/fifo_io.sv
// Input-buffer FIFO interface; the FIFO presents the head flit (first-word-fall-through)
// together with the destination address field it decodes from that flit.
interface FifoIO #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDRESS_SIZE = 4
);
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    wr_en;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    rd_en;
  logic                    empty;
  logic [ADDRESS_SIZE-1:0] pkt_address;

  modport ctrl (
    output wr_data, wr_en, rd_en,
    input  rd_data, empty, pkt_address
  );

  modport fifo (
    input  wr_data, wr_en, rd_en,
    output rd_data, empty, pkt_address
  );
endinterface

// File: rtl/route_ctrl_xy_route.sv
// Dimension-ordered (X first, then Y) route decision for one destination address.
module xy_route
  import noc_pkg::*;
#(
  parameter int ADDRESS_SIZE = 4
) (
  input  logic [ADDRESS_SIZE-1:0]   dst_addr_i,
  input  logic [ADDRESS_SIZE/2-1:0] local_x_i,
  input  logic [ADDRESS_SIZE/2-1:0] local_y_i,
  output logic [NUM_PORTS-1:0]      port_oh_o
);
  localparam int HALF = ADDRESS_SIZE / 2;

  logic [HALF-1:0] dst_x;
  logic [HALF-1:0] dst_y;

  assign dst_x = dst_addr_i[ADDRESS_SIZE-1 -: HALF];
  assign dst_y = dst_addr_i[HALF-1:0];

  always_comb begin
    if (dst_x > local_x_i)      port_oh_o = port_onehot(EAST);
    else if (dst_x < local_x_i) port_oh_o = port_onehot(WEST);
    else if (dst_y > local_y_i) port_oh_o = port_onehot(NORTH);
    else if (dst_y < local_y_i) port_oh_o = port_onehot(SOUTH);
    else                        port_oh_o = port_onehot(LOCAL);
  end

endmodule

// File: rtl/route_ctrl.sv
// Per-input route controller: parses a header, requests an output port, forwards the packet.
// Optional ROUTE_CTRL_PKT_CNT_EN adds a 16-bit wrapping completed-packet counter output.
module route_ctrl
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDRESS_SIZE = 4,
  parameter int LOCAL_X      = 0,
  parameter int LOCAL_Y      = 0,
  parameter int LEN_W        = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  FifoIO.ctrl                   fifo,
  output logic [NUM_PORTS-1:0]  req,
  input  logic                  grant,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
`ifdef ROUTE_CTRL_PKT_CNT_EN
  ,
  output logic [15:0]           pkt_count
`endif
);
  localparam int HALF = ADDRESS_SIZE / 2;
  localparam logic [HALF-1:0] LOC_X = HALF'(LOCAL_X);
  localparam logic [HALF-1:0] LOC_Y = HALF'(LOCAL_Y);

  state_e                 state_q;
  logic [NUM_PORTS-1:0]   req_q;
  logic [LEN_W:0]         remaining_q;
  logic [LEN_W:0]         remaining_d;
  logic [NUM_PORTS-1:0]   route_oh;
  logic                   accept;
  logic                   last_flit;

  xy_route #(
    .ADDRESS_SIZE(ADDRESS_SIZE)
  ) u_xy_route (
    .dst_addr_i(fifo.pkt_address),
    .local_x_i (LOC_X),
    .local_y_i (LOC_Y),
    .port_oh_o (route_oh)
  );

  // Header length counts payload only; the counter tracks header + payload.
  assign remaining_d = {1'b0, fifo.rd_data[LEN_W-1:0]} + (LEN_W+1)'(1);

  assign out_valid    = (state_q == XFER) && grant && !fifo.empty;
  assign accept       = out_valid && out_ready;
  assign last_flit    = accept && (remaining_q == (LEN_W+1)'(1));
  assign out_data     = fifo.rd_data;
  assign req          = req_q;
  assign fifo.rd_en   = accept;
  assign fifo.wr_en   = 1'b0;
  assign fifo.wr_data = '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      req_q       <= '0;
      remaining_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo.empty) begin
            req_q       <= route_oh;
            remaining_q <= remaining_d;
            state_q     <= REQ;
          end
        end
        REQ: begin
          if (grant) state_q <= XFER;
        end
        XFER: begin
          if (accept) begin
            remaining_q <= remaining_q - (LEN_W+1)'(1);
            if (last_flit) begin
              req_q   <= '0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ROUTE_CTRL_PKT_CNT_EN
  logic [15:0] pkt_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            pkt_cnt_q <= '0;
    else if (last_flit) pkt_cnt_q <= pkt_cnt_q + 16'd1;
  end

  assign pkt_count = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_route_ctrl.sv
// Bench for route_ctrl at LOCAL=(1,1): queue-based FIFO, XY/packet-level model checked every cycle,
// plus literal per-scenario expectations. Header layout here: [15:12] destination, [3:0] length.
module tb_route_ctrl;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  FifoIO #(.DATA_WIDTH(DW), .ADDRESS_SIZE(AW)) fifo_if ();

  logic [4:0]    req;
  logic          grant;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
`ifdef ROUTE_CTRL_PKT_CNT_EN
  logic [15:0]   pkt_count;
`endif

  route_ctrl #(
    .DATA_WIDTH  (DW),
    .ADDRESS_SIZE(AW),
    .LOCAL_X     (1),
    .LOCAL_Y     (1),
    .LEN_W       (LW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .fifo     (fifo_if),
    .req      (req),
    .grant    (grant),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef ROUTE_CTRL_PKT_CNT_EN
    ,
    .pkt_count(pkt_count)
`endif
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];

  // Model: phase 0 waiting for a header, 1 requesting, 2 forwarding.
  int          m_phase;
  logic [4:0]  m_port;
  int          m_left;
  int          m_done;
  logic [15:0] m_cnt;

  logic        grant_en;
  logic        toggle_ready;
  logic [4:0]  last_req;
  logic        last_valid;
  int          cyc;
  int          acc_cnt;
  int          first_acc;
  int          last_acc;
  int          bad_rd;
  logic [4:0]  req_seen;
  logic [15:0] pay_seq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [4:0] xy_expect(input logic [3:0] dst);
    int dx;
    int dy;
    dx = int'(dst[3:2]);
    dy = int'(dst[1:0]);
    if (dx > 1) return 5'b00010;
    if (dx < 1) return 5'b01000;
    if (dy > 1) return 5'b00001;
    if (dy < 1) return 5'b00100;
    return 5'b10000;
  endfunction

  task automatic fifo_drive();
    logic [DW-1:0] head;
    head = (fq.size() == 0) ? 16'hFFFF : fq[0];
    fifo_if.empty       = (fq.size() == 0);
    fifo_if.rd_data     = head;
    fifo_if.pkt_address = head[15:12];
  endtask

  task automatic push(input logic [DW-1:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
    fifo_drive();
  endtask

  task automatic push_hdr(input logic [3:0] dst, input logic [3:0] len);
    push({dst, 8'h00, len});
  endtask

  task automatic push_pay(input int n);
    for (int i = 0; i < n; i++) begin
      pay_seq = pay_seq + 16'd1;
      push(16'hA000 | pay_seq);
    end
  endtask

  task automatic reset_stats();
    acc_cnt   = 0;
    first_acc = -1;
    last_acc  = -1;
    bad_rd    = 0;
    req_seen  = '0;
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_port  = '0;
    m_left  = 0;
    m_cnt   = '0;
  endtask

  // One clock cycle: compare at negedge, then advance FIFO, model and bench arbiter after posedge.
  task automatic step();
    logic [4:0]    exp_req;
    logic          exp_v;
    logic          exp_r;
    logic          e_now;
    logic          pop;
    logic [DW-1:0] h;
    logic [DW-1:0] want;
    int            n_phase;
    int            n_left;
    logic [4:0]    n_port;
    @(negedge clk);
    e_now   = (fq.size() == 0);
    exp_req = (m_phase == 0) ? 5'b0 : m_port;
    exp_v   = (m_phase == 2) && grant && !e_now;
    exp_r   = exp_v && out_ready;
    chk("req", 32'(req), 32'(exp_req));
    chk("out_valid", 32'(out_valid), 32'(exp_v));
    chk("rd_en", 32'(fifo_if.rd_en), 32'(exp_r));
    chk("wr_en", 32'(fifo_if.wr_en), 32'(0));
    chk("wr_data", 32'(fifo_if.wr_data), 32'(0));
`ifdef ROUTE_CTRL_PKT_CNT_EN
    chk("pkt_count", 32'(pkt_count), 32'(m_cnt));
`endif
    if (exp_r) begin
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(want));
      end
      acc_cnt++;
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
    end
    if (fifo_if.rd_en && !out_ready) bad_rd++;
    if (req != 5'b0) req_seen = req;
    last_req   = req;
    last_valid = out_valid;
    pop        = fifo_if.rd_en;

    n_phase = m_phase;
    n_port  = m_port;
    n_left  = m_left;
    case (m_phase)
      0: if (!e_now) begin
        h       = fq[0];
        n_port  = xy_expect(h[15:12]);
        n_left  = int'(h[3:0]) + 1;
        n_phase = 1;
      end
      1: if (grant) n_phase = 2;
      default: if (exp_r) begin
        n_left = n_left - 1;
        if (n_left == 0) begin
          n_phase = 0;
          m_done++;
          m_cnt = m_cnt + 16'd1;
        end
      end
    endcase

    @(posedge clk);
    #1;
    m_phase = n_phase;
    m_port  = n_port;
    m_left  = n_left;
    if (pop && fq.size() > 0) void'(fq.pop_front());
    fifo_drive();
    grant = grant_en && (last_req != 5'b0);
    if (toggle_ready) out_ready = !out_ready;
    cyc++;
  endtask

  task automatic run_done(input int target);
    for (int i = 0; i < 200 && m_done < target; i++) step();
    if (m_done < target) begin
      tests_run++;
      tests_failed++;
      $display("FAIL timeout: packets done %0d, expected %0d", m_done, target);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    grant        = 1'b0;
    out_ready    = 1'b1;
    grant_en     = 1'b1;
    toggle_ready = 1'b0;
    cyc          = 0;
    m_done       = 0;
    pay_seq      = '0;
    last_req     = '0;
    last_valid   = 1'b0;
    model_reset();
    reset_stats();
    fifo_drive();

    // Reset asserted before any clock edge.
    #1 rst = 1'b1;
    #2;
    chk("rst_req", 32'(req), 32'(0));
    chk("rst_valid", 32'(out_valid), 32'(0));
    chk("rst_rd_en", 32'(fifo_if.rd_en), 32'(0));
    chk("rst_wr_en", 32'(fifo_if.wr_en), 32'(0));
    @(posedge clk);
    #1 rst = 1'b0;

    // EAST, len 2: three consecutive flits, req drops after the third.
    reset_stats();
    push_hdr(4'hB, 4'd2);
    push_pay(2);
    run_done(m_done + 1);
    step();
    chk("p1_req", 32'(req_seen), 32'(5'b00010));
    chk("p1_flits", 32'(acc_cnt), 32'(3));
    chk("p1_consec", 32'(last_acc - first_acc), 32'(2));
    chk("p1_req_drop", 32'(last_req), 32'(0));

    // LOCAL, len 0: header-only packet.
    reset_stats();
    push_hdr(4'h5, 4'd0);
    run_done(m_done + 1);
    step();
    chk("p2_req", 32'(req_seen), 32'(5'b10000));
    chk("p2_flits", 32'(acc_cnt), 32'(1));
    chk("p2_req_drop", 32'(last_req), 32'(0));

    // WEST, len 3 with out_ready toggling every cycle.
    reset_stats();
    toggle_ready = 1'b1;
    push_hdr(4'h0, 4'd3);
    push_pay(3);
    run_done(m_done + 1);
    toggle_ready = 1'b0;
    out_ready    = 1'b1;
    step();
    chk("p3_req", 32'(req_seen), 32'(5'b01000));
    chk("p3_flits", 32'(acc_cnt), 32'(4));
    chk("p3_rd_wo_ready", 32'(bad_rd), 32'(0));

    // NORTH, len 3 with the FIFO running dry after the second flit for three cycles.
    reset_stats();
    push_hdr(4'h6, 4'd3);
    push_pay(1);
    for (int i = 0; i < 50 && fq.size() > 0; i++) step();
    chk("p4_drained", 32'(fq.size()), 32'(0));
    for (int i = 0; i < 3; i++) begin
      step();
      chk("p4_gap_valid", 32'(last_valid), 32'(0));
      chk("p4_gap_req", 32'(last_req), 32'(5'b00001));
    end
    push_pay(2);
    run_done(m_done + 1);
    chk("p4_flits", 32'(acc_cnt), 32'(4));

    // SOUTH, len 1 with grant withheld for a while: request held, nothing forwarded.
    reset_stats();
    grant_en = 1'b0;
    push_hdr(4'h4, 4'd1);
    push_pay(1);
    for (int i = 0; i < 4; i++) step();
    chk("p5_hold_req", 32'(last_req), 32'(5'b00100));
    chk("p5_hold_valid", 32'(last_valid), 32'(0));
    grant_en = 1'b1;
    run_done(m_done + 1);
    chk("p5_flits", 32'(acc_cnt), 32'(2));

    // Reset mid-transfer, then a fresh packet must route correctly.
    reset_stats();
    push_hdr(4'hF, 4'd5);
    push_pay(5);
    for (int i = 0; i < 50 && acc_cnt < 2; i++) step();
    chk("p6_mid_valid", 32'(out_valid), 32'(1));
    rst = 1'b1;
    #1;
    chk("p6_rst_req", 32'(req), 32'(0));
    chk("p6_rst_valid", 32'(out_valid), 32'(0));
    chk("p6_rst_rd_en", 32'(fifo_if.rd_en), 32'(0));
    fq.delete();
    exp_q.delete();
    fifo_drive();
    model_reset();
    grant    = 1'b0;
    last_req = '0;
    #1 rst = 1'b0;
    reset_stats();
    push_hdr(4'h1, 4'd1);
    push_pay(1);
    run_done(m_done + 1);
    chk("p7_req", 32'(req_seen), 32'(5'b01000));
    chk("p7_flits", 32'(acc_cnt), 32'(2));

`ifdef ROUTE_CTRL_PKT_CNT_EN
    // Counter wrap: preload all-ones, one more packet must bring it to zero.
    step();
    force dut.pkt_cnt_q = 16'hFFFF;
    #1;
    release dut.pkt_cnt_q;
    m_cnt = 16'hFFFF;
    chk("cnt_preload", 32'(pkt_count), 32'(16'hFFFF));
    push_hdr(4'h5, 4'd0);
    run_done(m_done + 1);
    step();
    chk("cnt_wrap", 32'(pkt_count), 32'(0));
`endif

    step();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
